// File: rtl/popcount_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : popcount_seq_pkg
// Brief    : Shared sizing constants, state encoding and helpers for the
//            sequential popcount controller.
// Options  : none (POPCNT_EARLY_EXIT_EN is consumed by popcount_seq_ctrl)
// Revision : 1.0 - initial release
// ============================================================================
package popcount_seq_pkg;

   localparam int DATA_W  = 255;
   localparam int CHUNK_W = 32;
   localparam int NCHUNK  = (DATA_W + CHUNK_W - 1) / CHUNK_W;
   localparam int CNT_W   = $clog2(DATA_W + 1);
   localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int PC_W    = $clog2(CHUNK_W + 1);
   localparam int SH_W    = NCHUNK * CHUNK_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Zero-extend one chunk count to accumulator width.
   function automatic logic [CNT_W-1:0] zext_cnt(input logic [PC_W-1:0] c);
      return {{(CNT_W - PC_W){1'b0}}, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/popcount_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : popcount_seq_ctrl_if
// Brief    : Input-vector and result handshakes of the sequential popcount
//            controller. The controller binds the slave modport.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
interface popcount_seq_ctrl_if;

   logic [popcount_seq_pkg::DATA_W-1:0] in;
   logic                                in_valid;
   logic                                in_ready;
   logic [popcount_seq_pkg::CNT_W-1:0]  out;
   logic                                out_valid;
   logic                                out_ready;
   logic                                busy;

   modport slave (
      input  in, in_valid, out_ready,
      output in_ready, out, out_valid, busy
   );

   modport master (
      output in, in_valid, out_ready,
      input  in_ready, out, out_valid, busy
   );

endinterface
`default_nettype wire

// File: rtl/popcount_seq_ctrl_chunk.sv
`default_nettype none
// ============================================================================
// Module   : popcount_chunk
// Brief    : Purely combinational population count of one CHUNK_W-bit chunk.
//            Shared by the controller across all chunks of a vector.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module popcount_chunk #(
   parameter int CHUNK_W = 32,
   parameter int OUT_W   = $clog2(CHUNK_W + 1)
) (
   input  logic [CHUNK_W-1:0] chunk_i,
   output logic [OUT_W-1:0]   count_o
);

   // Add up every bit of the chunk.
   always_comb begin
      count_o = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         count_o = count_o + OUT_W'(chunk_i[i]);
      end
   end

endmodule
`default_nettype wire

// File: rtl/popcount_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : popcount_seq_ctrl
// Brief    : Counts the set bits of a DATA_W-bit vector by walking it
//            LSB-first, one CHUNK_W chunk per cycle, through a single shared
//            popcount_chunk instance, then offers the total on a handshake.
// Options  : POPCNT_EARLY_EXIT_EN - finish as soon as the remaining chunks
//            are all zero instead of always walking NCHUNK chunks.
// Revision : 1.0 - initial release
// ============================================================================
module popcount_seq_ctrl
   import popcount_seq_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   popcount_seq_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_COUNT = COUNT;
   localparam logic [1:0] S_DONE  = DONE;

   logic [1:0]       state_q, state_d;
   logic [SH_W-1:0]  sh_q,    sh_d;
   logic [CNT_W-1:0] acc_q,   acc_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [PC_W-1:0]  chunk_cnt;

   // The single shared counter always looks at the lowest chunk of sh.
   popcount_chunk #(
      .CHUNK_W (CHUNK_W),
      .OUT_W   (PC_W)
   ) u_chunk (
      .chunk_i (sh_q[CHUNK_W-1:0]),
      .count_o (chunk_cnt)
   );

   // Next-state: accept in IDLE, accumulate-and-shift in COUNT, hold in DONE.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               // Pad bits above DATA_W stay zero so they never count.
               sh_d             = '0;
               sh_d[DATA_W-1:0] = bus.in;
               acc_d            = '0;
               idx_d            = '0;
               state_d          = S_COUNT;
            end
         end
         S_COUNT: begin
            acc_d = acc_q + zext_cnt(chunk_cnt);
            sh_d  = sh_q >> CHUNK_W;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NCHUNK - 1)) begin
               state_d = S_DONE;
            end
`ifdef POPCNT_EARLY_EXIT_EN
            // Nothing left to count: the total is already final.
            if (sh_d == '0) begin
               state_d = S_DONE;
            end
`endif
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight vector.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.out       = acc_q;
   assign bus.busy      = (state_q == S_COUNT) || (state_q == S_DONE);

endmodule
`default_nettype wire
